fetch_stage: RTL
================

Name: fetch_stage

Overview:
Instruction-fetch stage for the MIPS datapath, directly upstream of main_decoder.
- Owns the PC and issues requests to instruction memory over a req/ack handshake.
- Redirects to the branch target when EX resolves a taken beq.
- Holds the IF/ID pipeline register, whose instr[31:26] feeds main_decoder.opcode.
- Supports stall (hazard unit) and flush (taken branch).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, instruction written into IF/ID on flush or bubble (sll $0,$0,0).

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  32  byte address of the request; equals pc.
imem_ack  input  1  response valid; may assert in the same cycle as imem_req.
imem_rdata  input  32  instruction word, valid only when imem_ack=1.
stall  input  1  ID stage cannot accept a new instruction; IF/ID must hold.
branch_taken  input  1  Branch & Zero from EX; redirect required.
branch_target  input  32  redirect PC, sampled when branch_taken=1.
if_id_valid  output  1  IF/ID holds a real instruction.
if_id_instr  output  32  IF/ID instruction register.
if_id_pc_plus4  output  32  PC+4 of the instruction in IF/ID.
opcode  output  6  combinational if_id_instr[31:26], to main_decoder.

Behaviour:
Reset:
- Asynchronous on rst_n=0.
- pc=RESET_PC, state=S_BOOT, imem_req=0, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc_plus4=0, skid buffer empty, redirect_pending=0.
- Reset asserted mid-transaction abandons any in-flight request; memory must tolerate the dropped req.

FSM states:
- S_BOOT: imem_req=0 for one cycle after reset release -> S_FETCH.
- S_FETCH: imem_req=1, imem_addr=pc. imem_addr is held stable while req=1 and ack=0.
  - ack & !redirect & (!stall | !if_id_valid): IF/ID <= {1, rdata, pc+4}; pc <= pc+4; stay. Throughput is one instruction per cycle with zero-wait memory.
  - ack & stall & if_id_valid: skid <= {rdata, pc+4}; pc <= pc+4 -> S_BUF.
  - no ack: IF/ID unchanged unless flushed.
- S_BUF: imem_req=0; IF/ID holds while stall=1.
  - stall=0: IF/ID <= {1, skid}; skid cleared -> S_FETCH.
- S_DRAIN: entered when a redirect arrives while a request is outstanding (req=1, ack=0).
  - Keeps req=1 with the old address until ack, then discards rdata.
  - pc <= saved redirect target -> S_FETCH.

Redirect (branch_taken=1), top priority in every state:
- Overrides stall and any simultaneous ack.
- Flush: if_id_valid <= 0, if_id_instr <= NOP_INSTR. Skid buffer is discarded.
- S_FETCH with ack in the same cycle: rdata discarded; pc <= branch_target; stay in S_FETCH.
- S_FETCH without ack: target saved into redirect_pc -> S_DRAIN.
- S_BUF or S_BOOT: pc <= branch_target -> S_FETCH.
- S_DRAIN: a second redirect overwrites redirect_pc (newest wins).

Stall:
- stall=1 with if_id_valid=0 is a no-op; an empty IF/ID is filled regardless of stall.

Width and arithmetic:
- pc+4 computed modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- pc[1:0] is always 0; branch_target[1:0] is ignored and forced to 0.

Decomposition:
- Shared package mips_pkg holds:
  - state encodings S_BOOT/S_FETCH/S_BUF/S_DRAIN;
  - NOP_INSTR;
  - opcode constants OP_RTYPE=6'h00, OP_LW=6'h23, OP_SW=6'h2B, OP_BEQ=6'h04 (shared with main_decoder).
- One natural sub-module, if_id_reg: the IF/ID register with async reset, load, hold and flush controls; flush has priority over load.

Test Plan:
- Reset, zero-wait memory (ack same cycle), no stall -> imem_addr 0,4,8,C on successive cycles; if_id_pc_plus4 4,8,C; opcode tracks rdata[31:26] (e.g. 6'h23 for 32'h8C010004).
- stall=1 for 3 cycles with if_id_valid=1 -> one extra fetch goes to the skid buffer, then req=0; IF/ID constant; after release, skid moves to IF/ID and fetch resumes at the next pc.
- 2-cycle-latency memory, branch_taken=1 (target 32'h40) on the req cycle before ack -> S_DRAIN; old address held until ack; rdata dropped; next req at 32'h40; IF/ID flushed to NOP with valid=0.
- branch_taken and imem_ack in the same cycle with stall=1 -> flush wins: if_id_valid=0, pc=target, fetched word discarded.
- pc=32'hFFFF_FFFC, ack -> pc wraps to 0; if_id_pc_plus4=0.
- rst_n pulsed low asynchronously mid-S_DRAIN -> all outputs at reset values within the same cycle; after release, one S_BOOT cycle, then req at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: fetch FSM states,
// IF/ID bundle and primary opcode constants.
package mips_pkg;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_BUF   = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } if_id_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with load/hold/flush.
// Flush beats load so a redirect always kills the slot.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP = 32'h0000_0000
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush_i,
  input  logic   load_i,
  input  if_id_t d_i,
  output logic   valid_o,
  output if_id_t q_o
);

  logic   valid_q;
  if_id_t data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '{instr: NOP, pc_plus4: 32'h0};
    end else if (flush_i) begin
      valid_q      <= 1'b0;
      data_q.instr <= NOP;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= d_i;
    end
  end

  assign valid_o = valid_q;
  assign q_o     = data_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction fetch: PC, imem req/ack,
// skid buffer for stalls, branch redirect and IF/ID.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic [5:0]  opcode
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_q, redir_d;
  if_id_t      skid_q, skid_d;

  logic        load, flush;
  if_id_t      ld_data, if_id;
  logic [31:0] pc4, tgt;

  assign pc4 = pc_q + 32'd4;
  assign tgt = branch_target & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      redir_q <= 32'h0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    redir_d = redir_q;
    skid_d  = skid_q;
    load    = 1'b0;
    flush   = 1'b0;
    ld_data = '{instr: imem_rdata, pc_plus4: pc4};
    unique case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
        if (branch_taken) begin
          flush = 1'b1;
          pc_d  = tgt;
        end
      end
      S_FETCH: begin
        if (branch_taken) begin
          flush = 1'b1;
          if (imem_ack) begin
            pc_d = tgt;
          end else begin
            redir_d = tgt;
            state_d = S_DRAIN;
          end
        end else if (imem_ack) begin
          pc_d = pc4;
          if (!stall || !if_id_valid) begin
            load = 1'b1;
          end else begin
            skid_d  = '{instr: imem_rdata, pc_plus4: pc4};
            state_d = S_BUF;
          end
        end
      end
      S_BUF: begin
        ld_data = skid_q;
        if (branch_taken) begin
          flush   = 1'b1;
          pc_d    = tgt;
          skid_d  = '0;
          state_d = S_FETCH;
        end else if (!stall) begin
          load    = 1'b1;
          skid_d  = '0;
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        // the outstanding word is always dropped; newest target wins
        if (branch_taken) begin
          flush   = 1'b1;
          redir_d = tgt;
        end
        if (imem_ack) begin
          pc_d    = branch_taken ? tgt : redir_q;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_comb begin
    imem_req  = (state_q == S_FETCH) || (state_q == S_DRAIN);
    imem_addr = pc_q;
  end

  if_id_reg #(
    .NOP(NOP_INSTR)
  ) u_if_id (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush_i(flush),
    .load_i (load),
    .d_i    (ld_data),
    .valid_o(if_id_valid),
    .q_o    (if_id)
  );

  assign if_id_instr    = if_id.instr;
  assign if_id_pc_plus4 = if_id.pc_plus4;
  assign opcode         = if_id.instr[31:26];

endmodule
